// File: rtl/ysyx_23060240_pkg.sv
// Shared types and constants for the ysyx_23060240 memory arbiter.
package ysyx_23060240_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      ERR  = 2'd3
   } state_e;

   // Owner encoding, also used as the round-robin grant index
   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   // Default response timeout in RESP cycles
   localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/ysyx_23060240_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester not granted last wins.
module ysyx_23060240_rr_arb2
   import ysyx_23060240_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant
);

   // Pick the sole requester, or alternate against last_grant on a tie
   always_comb begin
      grant = OWN_IFU;
      if (req[1] && req[0]) begin
         grant = ~last_grant;
      end else if (req[1]) begin
         grant = OWN_LSU;
      end
   end

endmodule

// File: rtl/ysyx_23060240_mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction outstanding,
// with a bounded response timeout that returns an error response.
module ysyx_23060240_mem_arbiter
   import ysyx_23060240_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   // IFU
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_req_addr,
   output logic                ifu_resp_valid,
   input  logic                ifu_resp_ready,
   output logic [DATA_W-1:0]   ifu_resp_data,
   output logic                ifu_resp_err,
   // LSU
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_req_addr,
   input  logic                lsu_req_wen,
   input  logic [DATA_W-1:0]   lsu_req_wdata,
   input  logic [DATA_W/8-1:0] lsu_req_wstrb,
   output logic                lsu_resp_valid,
   input  logic                lsu_resp_ready,
   output logic [DATA_W-1:0]   lsu_resp_data,
   output logic                lsu_resp_err,
   // Memory
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_wen,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wstrb,
   input  logic                mem_resp_valid,
   output logic                mem_resp_ready,
   input  logic [DATA_W-1:0]   mem_resp_data,
   input  logic                mem_resp_err,
   // Status
   output logic                busy,
   output logic                owner
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_e           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_grant_q, last_grant_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             grant;
   logic             owner_resp_ready;

   ysyx_23060240_rr_arb2 u_rr_arb2 (
      .req        ({lsu_req_valid, ifu_req_valid}),
      .last_grant (last_grant_q),
      .grant      (grant)
   );

   assign busy  = (state_q != IDLE);
   assign owner = owner_q;
   assign owner_resp_ready = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

   // State, owner, round-robin history and timeout counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= OWN_IFU;
         last_grant_q <= OWN_IFU;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
      end
   end

   // Next-state logic and request/response routing
   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      last_grant_d   = last_grant_q;
      cnt_d          = cnt_q;

      ifu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      ifu_resp_data  = '0;
      ifu_resp_err   = 1'b0;
      lsu_req_ready  = 1'b0;
      lsu_resp_valid = 1'b0;
      lsu_resp_data  = '0;
      lsu_resp_err   = 1'b0;
      mem_req_valid  = 1'b0;
      mem_req_addr   = '0;
      mem_req_wen    = 1'b0;
      mem_req_wdata  = '0;
      mem_req_wstrb  = '0;
      mem_resp_ready = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Drain stray responses (late after timeout or after reset)
            mem_resp_ready = 1'b1;
            if (ifu_req_valid || lsu_req_valid) begin
               owner_d = grant;
               state_d = REQ;
            end
         end

         REQ: begin
            mem_req_valid = 1'b1;
            if (owner_q == OWN_LSU) begin
               mem_req_addr  = lsu_req_addr;
               mem_req_wen   = lsu_req_wen;
               mem_req_wdata = lsu_req_wdata;
               mem_req_wstrb = lsu_req_wstrb;
               lsu_req_ready = mem_req_ready;
            end else begin
               mem_req_addr  = ifu_req_addr;
               ifu_req_ready = mem_req_ready;
            end
            if (mem_req_ready) begin
               state_d      = RESP;
               cnt_d        = '0;
               last_grant_d = owner_q;
            end
         end

         RESP: begin
            mem_resp_ready = owner_resp_ready;
            if (owner_q == OWN_LSU) begin
               lsu_resp_valid = mem_resp_valid;
               lsu_resp_data  = mem_resp_data;
               lsu_resp_err   = mem_resp_err;
            end else begin
               ifu_resp_valid = mem_resp_valid;
               ifu_resp_data  = mem_resp_data;
               ifu_resp_err   = mem_resp_err;
            end
            if (mem_resp_valid) begin
               if (owner_resp_ready) begin
                  state_d = IDLE;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = ERR;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ERR: begin
            if (owner_q == OWN_LSU) begin
               lsu_resp_valid = 1'b1;
               lsu_resp_err   = 1'b1;
            end else begin
               ifu_resp_valid = 1'b1;
               ifu_resp_err   = 1'b1;
            end
            if (owner_resp_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ysyx_23060240_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter (built with TIMEOUT=4).
module tb_ysyx_23060240_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
   logic [31:0] ifu_req_addr, ifu_resp_data;
   logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
   logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
   logic [3:0]  lsu_req_wstrb;
   logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid, mem_resp_ready, mem_resp_err;
   logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
   logic [3:0]  mem_req_wstrb;
   logic        busy, owner;

   int vectors = 0;
   int errs    = 0;

   always #5 clk = ~clk;

   ysyx_23060240_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
      .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
      .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
      .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
      .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
      .busy(busy), .owner(owner)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      ifu_req_valid = 0; ifu_req_addr = 0; ifu_resp_ready = 0;
      lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wstrb = 0;
      lsu_resp_ready = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0; mem_resp_err = 0;
      tick(); tick();

      // Reset state
      chk("rst_busy", 64'(busy), 0);
      chk("rst_owner", 64'(owner), 0);
      chk("rst_mem_resp_ready", 64'(mem_resp_ready), 1);
      chk("rst_mem_req_valid", 64'(mem_req_valid), 0);
      chk("rst_ifu_req_ready", 64'(ifu_req_ready), 0);
      chk("rst_lsu_resp_valid", 64'(lsu_resp_valid), 0);
      chk("rst_mem_req_addr", 64'(mem_req_addr), 0);
      rst = 1'b0;

      // IFU alone, response after 2 RESP cycles
      ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000; #1;
      chk("t1_idle_req_valid", 64'(mem_req_valid), 0);
      tick();
      chk("t1_req_valid", 64'(mem_req_valid), 1);
      chk("t1_req_addr", 64'(mem_req_addr), 64'h8000_0000);
      chk("t1_req_wen", 64'(mem_req_wen), 0);
      chk("t1_owner", 64'(owner), 0);
      chk("t1_busy", 64'(busy), 1);
      mem_req_ready = 1; #1;
      chk("t1_ifu_req_ready", 64'(ifu_req_ready), 1);
      chk("t1_lsu_req_ready", 64'(lsu_req_ready), 0);
      tick();
      ifu_req_valid = 0; mem_req_ready = 0; ifu_resp_ready = 1; #1;
      chk("t1_resp_wait_valid", 64'(ifu_resp_valid), 0);
      chk("t1_resp_req_valid", 64'(mem_req_valid), 0);
      tick();
      mem_resp_valid = 1; mem_resp_data = 32'h0000_0413; #1;
      chk("t1_resp_valid", 64'(ifu_resp_valid), 1);
      chk("t1_resp_data", 64'(ifu_resp_data), 64'h413);
      chk("t1_resp_err", 64'(ifu_resp_err), 0);
      chk("t1_lsu_resp_valid", 64'(lsu_resp_valid), 0);
      chk("t1_lsu_resp_data", 64'(lsu_resp_data), 0);
      chk("t1_mem_resp_ready", 64'(mem_resp_ready), 1);
      tick();
      mem_resp_valid = 0; mem_resp_data = 0; #1;
      chk("t1_done_busy", 64'(busy), 0);

      // Tie: LSU store wins, then IFU
      lsu_req_valid = 1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1;
      lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wstrb = 4'hF;
      ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
      tick();
      mem_req_ready = 1; #1;
      chk("t2_owner_lsu", 64'(owner), 1);
      chk("t2_addr", 64'(mem_req_addr), 64'h8000_1000);
      chk("t2_wen", 64'(mem_req_wen), 1);
      chk("t2_wdata", 64'(mem_req_wdata), 64'hDEAD_BEEF);
      chk("t2_wstrb", 64'(mem_req_wstrb), 64'hF);
      chk("t2_lsu_req_ready", 64'(lsu_req_ready), 1);
      chk("t2_ifu_req_ready", 64'(ifu_req_ready), 0);
      tick();
      lsu_req_valid = 0; lsu_resp_ready = 1; mem_resp_valid = 1; #1;
      chk("t2_lsu_resp_valid", 64'(lsu_resp_valid), 1);
      chk("t2_ifu_resp_valid", 64'(ifu_resp_valid), 0);
      tick();
      mem_resp_valid = 0; #1;
      chk("t2_idle_req_valid", 64'(mem_req_valid), 0);
      chk("t2_idle_busy", 64'(busy), 0);
      tick();
      chk("t2_ifu_req_valid", 64'(mem_req_valid), 1);
      chk("t2_ifu_owner", 64'(owner), 0);
      chk("t2_ifu_addr", 64'(mem_req_addr), 64'h8000_0004);
      chk("t2_ifu_wen", 64'(mem_req_wen), 0);
      chk("t2_ifu_wdata", 64'(mem_req_wdata), 0);
      chk("t2_ifu_wstrb", 64'(mem_req_wstrb), 0);
      tick();
      ifu_req_valid = 0; mem_resp_valid = 1;
      tick();
      mem_resp_valid = 0; lsu_req_wen = 0;

      // Both continuously valid: alternating grants
      lsu_req_valid = 1; ifu_req_valid = 1; mem_resp_valid = 1; lsu_resp_ready = 1; ifu_resp_ready = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("t3_owner_%0d", i), 64'(owner), (i % 2 == 0) ? 1 : 0);
         tick();
         chk($sformatf("t3_resp_%0d", i),
             64'((i % 2 == 0) ? lsu_resp_valid : ifu_resp_valid), 1);
         tick();
         chk($sformatf("t3_idle_%0d", i), 64'(busy), 0);
      end
      lsu_req_valid = 0; ifu_req_valid = 0; mem_resp_valid = 0;

      // Timeout with TIMEOUT=4
      ifu_req_valid = 1; ifu_resp_ready = 0;
      tick();  // REQ
      tick();  // RESP cycle 1
      ifu_req_valid = 0; #1;
      chk("t4_r1_valid", 64'(ifu_resp_valid), 0);
      tick(); tick(); tick();  // RESP cycle 4
      chk("t4_r4_valid", 64'(ifu_resp_valid), 0);
      chk("t4_r4_busy", 64'(busy), 1);
      tick();  // ERR
      mem_resp_data = 32'h1234; #1;
      chk("t4_err_valid", 64'(ifu_resp_valid), 1);
      chk("t4_err_err", 64'(ifu_resp_err), 1);
      chk("t4_err_data", 64'(ifu_resp_data), 0);
      chk("t4_err_mem_ready", 64'(mem_resp_ready), 0);
      chk("t4_err_lsu_valid", 64'(lsu_resp_valid), 0);
      tick();
      chk("t4_err_hold", 64'(ifu_resp_valid), 1);
      ifu_resp_ready = 1;
      tick();  // IDLE
      mem_resp_valid = 1; mem_resp_data = 32'hBAD; #1;
      chk("t4_drain_ready", 64'(mem_resp_ready), 1);
      chk("t4_drain_fwd", 64'(ifu_resp_valid), 0);
      chk("t4_drain_busy", 64'(busy), 0);
      tick();
      mem_resp_valid = 0;

      // Response arrives on the cycle the counter reaches TIMEOUT-1
      ifu_req_valid = 1;
      tick(); tick();
      ifu_req_valid = 0;
      tick(); tick(); tick();  // RESP cycle 4
      mem_resp_valid = 1; mem_resp_data = 32'hCAFE_0001; #1;
      chk("t5_edge_valid", 64'(ifu_resp_valid), 1);
      chk("t5_edge_err", 64'(ifu_resp_err), 0);
      chk("t5_edge_data", 64'(ifu_resp_data), 64'hCAFE_0001);
      tick();
      mem_resp_valid = 0; #1;
      chk("t5_edge_idle", 64'(busy), 0);
      chk("t5_edge_no_err", 64'(ifu_resp_valid), 0);

      // Owner back-pressure on the response
      ifu_req_valid = 1;
      tick(); tick();
      ifu_req_valid = 0; ifu_resp_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'h55AA; #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t6_bp_ready_%0d", i), 64'(mem_resp_ready), 0);
         chk($sformatf("t6_bp_valid_%0d", i), 64'(ifu_resp_valid), 1);
         tick();
      end
      ifu_resp_ready = 1; #1;
      chk("t6_deliver_ready", 64'(mem_resp_ready), 1);
      chk("t6_deliver_data", 64'(ifu_resp_data), 64'h55AA);
      chk("t6_deliver_err", 64'(ifu_resp_err), 0);
      tick();
      mem_resp_valid = 0; #1;
      chk("t6_idle", 64'(busy), 0);

      // Reset in RESP, then a normal IFU transaction
      ifu_req_valid = 1;
      tick(); tick();
      ifu_req_valid = 0; #1;
      chk("t7_in_resp", 64'(busy), 1);
      rst = 1;
      tick();
      chk("t7_rst_busy", 64'(busy), 0);
      chk("t7_rst_owner", 64'(owner), 0);
      chk("t7_rst_mem_resp_ready", 64'(mem_resp_ready), 1);
      chk("t7_rst_ifu_resp_valid", 64'(ifu_resp_valid), 0);
      chk("t7_rst_mem_req_valid", 64'(mem_req_valid), 0);
      rst = 0; mem_resp_valid = 1; mem_resp_data = 32'hBEEF; #1;
      chk("t7_stray_fwd", 64'(ifu_resp_valid), 0);
      tick();
      mem_resp_valid = 0; ifu_req_valid = 1; ifu_req_addr = 32'h8000_0008;
      tick();
      chk("t7_req_valid", 64'(mem_req_valid), 1);
      chk("t7_req_addr", 64'(mem_req_addr), 64'h8000_0008);
      tick();
      ifu_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 32'h0010_0093; #1;
      chk("t7_resp_data", 64'(ifu_resp_data), 64'h0010_0093);
      chk("t7_resp_valid", 64'(ifu_resp_valid), 1);
      tick();
      mem_resp_valid = 0; #1;
      chk("t7_idle", 64'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
